// File: rtl/seq_array_mult_if.sv
// Operand/product handshake bundle for seq_array_mult.
// The producer/consumer side uses master; the multiplier uses slave.
interface seq_array_mult_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 is_signed;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/seq_array_mult.sv
// Iterative shift-and-add multiplier, one multiplier bit per clock, signed or unsigned.
// Operands are reduced to magnitudes at accept; the sign is restored when the product is loaded.
module seq_array_mult #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_array_mult_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q,   state_d;
  logic [WIDTH-1:0]     mcand_q,   mcand_d;
  logic [WIDTH-1:0]     mplier_q,  mplier_d;
  logic [2*WIDTH-1:0]   acc_q,     acc_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [CW-1:0]        cnt_q,     cnt_d;
  logic                 neg_q,     neg_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH:0]       partial;

  // -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    magnitude = (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v, input logic neg);
    apply_sign = neg ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    partial   = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    if (mplier_q[0]) partial = partial + {1'b0, mcand_q};

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mcand_d  = magnitude(bus.a, bus.is_signed);
          mplier_d = magnitude(bus.b, bus.is_signed);
          neg_d    = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        // Carry out of the upper add lands in the MSB after the shift.
        acc_d    = (2*WIDTH)'({partial, acc_q[WIDTH-1:0]} >> 1);
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d   = DONE;
          product_d = apply_sign(acc_d, neg_q);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      product_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      product_q   <= product_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;
endmodule

// File: tb/tb_seq_array_mult.sv
// Bench for seq_array_mult: directed WIDTH=8 cases plus concurrent random sweeps at WIDTH=2, 4, 16.
module tb_seq_array_mult;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8_n;
  logic rstsw_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   sw_done [3];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: interpret operands per mode, multiply as integers, keep 2*w bits.
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint av, bv, p;
    logic [63:0] mask;
    av = longint'(a);
    bv = longint'(b);
    if (sgn && a[w-1]) av = av - (longint'(1) << w);
    if (sgn && b[w-1]) bv = bv - (longint'(1) << w);
    p = av * bv;
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 64'(p) & mask;
  endfunction

  seq_array_mult_if #(.WIDTH(8)) b8 ();
  seq_array_mult #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst8_n), .bus(b8));

  for (genvar g = 0; g < 3; g++) begin : sw
    localparam int W = (g == 0) ? 2 : ((g == 1) ? 4 : 16);
    seq_array_mult_if #(.WIDTH(W)) bi ();
    seq_array_mult #(.WIDTH(W)) dut (.clk(clk), .rst_n(rstsw_n), .bus(bi));

    initial begin
      bi.in_valid  = 1'b0;
      bi.a         = '0;
      bi.b         = '0;
      bi.is_signed = 1'b0;
      bi.out_ready = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      for (int t = 0; t < 1000; t++) begin
        logic [W-1:0]   ra, rb;
        logic [2*W-1:0] held;
        bit             rs;
        int             lat, stalls;
        ra = W'($urandom);
        rb = W'($urandom);
        rs = 1'($urandom_range(0, 1));
        check($sformatf("w%0d_in_ready", W), 64'(bi.in_ready), 64'd1);
        bi.a = ra; bi.b = rb; bi.is_signed = rs; bi.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bi.in_valid  = 1'b0;
        bi.is_signed = ~rs;
        bi.a         = W'($urandom);
        bi.b         = W'($urandom);
        lat = 0;
        while (!bi.out_valid && lat < W + 4) begin
          bi.out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
          lat++;
        end
        check($sformatf("w%0d_latency", W), 64'(lat), 64'(W));
        check($sformatf("w%0d_product", W), 64'(bi.product), ref_mul(W, 32'(ra), 32'(rb), rs));
        held = bi.product;
        stalls = $urandom_range(0, 3);
        if (stalls > 0) begin
          bi.out_ready = 1'b0;
          repeat (stalls) begin @(posedge clk); #1; end
          check($sformatf("w%0d_hold", W), 64'({bi.out_valid, bi.product}), 64'({1'b1, held}));
        end
        bi.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bi.out_ready = 1'b0;
        check($sformatf("w%0d_post_hs", W), 64'({bi.out_valid, bi.in_ready}), 64'b01);
      end
      sw_done[g] = 1'b1;
    end
  end

  task automatic run8(input string tag, input logic [7:0] ra, input logic [7:0] rb, input bit rs,
                      input logic [15:0] exp);
    int lat;
    check({tag, "_in_ready"}, 64'(b8.in_ready), 64'd1);
    b8.a = ra; b8.b = rb; b8.is_signed = rs; b8.in_valid = 1'b1;
    @(posedge clk);
    #1;
    b8.in_valid  = 1'b0;
    b8.out_ready = 1'b1;
    lat = 0;
    while (!b8.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check({tag, "_latency"}, 64'(lat), 64'd8);
    check({tag, "_product"}, 64'(b8.product), 64'(exp));
    @(posedge clk);
    #1;
    check({tag, "_valid_1cyc"}, 64'(b8.out_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(b8.in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    rst8_n = 1'b0;
    rstsw_n = 1'b0;
    b8.in_valid = 1'b0; b8.a = '0; b8.b = '0; b8.is_signed = 1'b0; b8.out_ready = 1'b0;
    #12;
    check("rst_in_ready", 64'(b8.in_ready), 64'd1);
    check("rst_out_valid", 64'(b8.out_valid), 64'd0);
    check("rst_product", 64'(b8.product), 64'd0);
    #10;
    rst8_n = 1'b1;
    rstsw_n = 1'b1;
    @(posedge clk);
    #1;

    run8("u13x11", 8'd13, 8'd11, 1'b0, 16'h008F);
    run8("uffxff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    run8("sffxff", 8'hFF, 8'hFF, 1'b1, 16'h0001);
    run8("s80x80", 8'h80, 8'h80, 1'b1, 16'h4000);
    run8("s80x01", 8'h80, 8'h01, 1'b1, 16'hFF80);
    run8("sffx01", 8'hFF, 8'h01, 1'b1, 16'hFFFF);

    // Backpressure: hold the result while new operands are offered.
    b8.out_ready = 1'b0;
    b8.a = 8'h25; b8.b = 8'h13; b8.is_signed = 1'b0; b8.in_valid = 1'b1;
    @(posedge clk);
    #1;
    b8.in_valid = 1'b0;
    lat = 0;
    while (!b8.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("bp_latency", 64'(lat), 64'd8);
    for (int i = 0; i < 5; i++) begin
      b8.a = 8'(i + 8'h11); b8.b = 8'h22; b8.is_signed = 1'b1; b8.in_valid = 1'(i % 2 == 0);
      @(posedge clk);
      #1;
      check("bp_hold", 64'({b8.out_valid, b8.in_ready, b8.product}), 64'({2'b10, 16'h02BF}));
    end
    b8.in_valid = 1'b0;
    b8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    b8.out_ready = 1'b0;
    check("bp_release", 64'({b8.out_valid, b8.in_ready}), 64'b01);
    check("bp_product_kept", 64'(b8.product), 64'h02BF);

    // Asynchronous reset during the 4th CALC cycle.
    b8.a = 8'h5A; b8.b = 8'h3C; b8.is_signed = 1'b0; b8.in_valid = 1'b1;
    @(posedge clk);
    #1;
    b8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst8_n = 1'b0;
    #1;
    check("arst_state", 64'({b8.in_ready, b8.out_valid, b8.product}), 64'({2'b10, 16'h0000}));
    #2;
    rst8_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_no_valid", 64'(b8.out_valid), 64'd0);
    run8("restart7x6", 8'd7, 8'd6, 1'b0, 16'h002A);

    for (int c = 0; c < 60000 && !(sw_done[0] && sw_done[1] && sw_done[2]); c++) @(posedge clk);
    check("sweep_finished", 64'({sw_done[0], sw_done[1], sw_done[2]}), 64'b111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seq_array_mult.md
# seq_array_mult

Parametrised, iterative shift-and-add multiplier with selectable signed or unsigned operation and valid/ready handshakes on both sides. It is the sequential, width-generic successor to the team's combinational 4-bit array multiplier. It trades one partial-product row per clock for a small area footprint, and sits between a producer and a consumer that both apply backpressure.

## Interface
Parameters:
- WIDTH, default 8: operand width in bits; legal range 2..32. The product is 2*WIDTH bits.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- in_valid, input, 1: operands and mode are presented.
- in_ready, output, 1: the block can accept operands.
- a, input, WIDTH: multiplicand.
- b, input, WIDTH: multiplier.
- is_signed, input, 1: 1 means a and b are two's complement; 0 means unsigned. Sampled only at accept.
- out_valid, output, 1: product is available.
- out_ready, input, 1: the consumer accepts the product.
- product, output, 2*WIDTH: result; signed or unsigned according to the captured mode.

## Operation
- States: IDLE, CALC, DONE. Reset state is IDLE.
- Reset values: in_ready=1, out_valid=0, product=0. The internal accumulator, counter and sign flag are all cleared to 0.
- in_ready is 1 only in IDLE. out_valid is 1 only in DONE. Both are decoded from registered state.
- IDLE to CALC: on an edge with in_valid && in_ready.
  - Capture |a| and |b| as WIDTH-bit magnitudes. Negate an operand only when is_signed=1 and its MSB is 1.
  - Capture neg = is_signed & (a[MSB] ^ b[MSB]).
  - Clear the 2*WIDTH-bit accumulator and the bit counter.
- CALC: processes one multiplier bit per edge, LSB first.
  - If the current multiplier bit is 1, add the multiplicand magnitude to the upper WIDTH+1 bits of the accumulator, keeping the carry.
  - Shift the accumulator right by one and increment the counter.
  - The counter is $clog2(WIDTH+1) bits wide.
- CALC to DONE: on the edge that processes bit WIDTH-1.
  - On that same edge, product is loaded with the accumulator, or with its 2*WIDTH-bit two's complement when neg=1.
- DONE to IDLE: on an edge with out_valid && out_ready.
  - product holds its value after the handshake until the next result is loaded. It is not cleared.
- Arithmetic rules:
  - The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which fits in WIDTH unsigned bits.
  - The maximum magnitude product is (2^WIDTH - 1)^2, which fits in 2*WIDTH bits.
  - No overflow is possible in either mode.
- Zero operands are not short-circuited. Latency is fixed regardless of data.
- Boundary conditions:
  - in_valid during CALC or DONE is ignored. No operand is captured, and the producer must hold its data.
  - out_ready while not in DONE has no effect.
  - In DONE, product and out_valid stay stable until accepted, independent of inputs.
  - rst_n low in any state immediately (asynchronously) forces the reset values. The in-flight operation is discarded and no out_valid pulse is produced.
  - Mode changes on is_signed after accept do not affect the running operation.

## Timing
- Accept edge E0. CALC occupies edges E1..E_WIDTH.
- out_valid and product are valid in the cycle following E_WIDTH, i.e. WIDTH cycles after acceptance.
- Minimum issue interval: WIDTH+2 cycles (accept, WIDTH compute edges, one output-handshake edge).
  - in_ready rises in the cycle after the output handshake.
  - No accept can occur in the same cycle as an output handshake.
- Throughput with out_ready held high: one product per WIDTH+2 cycles.
- All outputs are driven from registers. There is no combinational path from inputs to outputs.

## Test plan
- Unsigned, WIDTH=8, out_ready=1: a=13, b=11, is_signed=0 -> product=0x008F. out_valid rises exactly 8 cycles after the accept edge and stays high for 1 cycle. in_ready returns high on the next cycle.
- Unsigned and signed corner cases, WIDTH=8:
  - a=0xFF, b=0xFF unsigned -> 0xFE01.
  - Same operands signed -> 0x0001.
  - a=0x80, b=0x80 signed -> 0x4000.
  - a=0x80, b=0x01 signed -> 0xFF80.
  - a=0xFF, b=0x01 signed -> 0xFFFF.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises -> product and out_valid stay stable, in_ready stays 0, and in_valid pulses with new operands are ignored. Release out_ready -> handshake occurs, then in_ready=1 on the next cycle.
- Reset mid-operation: assert rst_n=0 at the 4th CALC cycle, asynchronously between edges -> in_ready=1, out_valid=0 and product=0 immediately. Restart with a=7, b=6 -> 0x002A after 8 cycles.
- Parameter sweep: WIDTH=2, 4, 16, with 1000 random operand/mode pairs each plus random out_ready stalls -> every product matches the reference model a*b, evaluated signed or unsigned per the captured mode. Latency is always WIDTH cycles from accept to out_valid.
